letter_rx: RTL and testbench
============================

# letter_rx

Serial-to-letter front end for the name sequence detector. Deserialises an asynchronous 8N1 bit stream on a single input line into 8-bit ASCII characters and presents each one as `letter` with a one-cycle `letter_valid` strobe. Optionally folds lower case to upper case so the downstream detector compares against one case only. Sits directly upstream of the detector's `letter` input.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, ≥ 4.
- `UPCASE`, 1: when 1, bytes 0x61–0x7A (`a`–`z`) are emitted minus 0x20; when 0, bytes pass unchanged.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `rxd`  in  1  serial line, idle high, LSB first, asynchronous to `clk`.
- `letter`  out  8  last correctly framed character; held until the next one.
- `letter_valid`  out  1  one-cycle pulse in the cycle `letter` takes a new value.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.

## Operation
- `rxd` passes through a 2-flop synchroniser whose flops reset to 1; its output is `rxd_s`. All decisions use `rxd_s` only.
- FSM states and transitions:
  - IDLE: when `rxd_s`=0, go to START and clear the counter.
  - START: count to H = `CLKS_PER_BIT`/2. If `rxd_s`=1 at the sample point, treat it as a false start and return to IDLE. Otherwise go to DATA with bit index 0.
  - DATA: sample every `CLKS_PER_BIT` cycles and shift into bit [index], LSB first. After bit 7, go to STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - `rxd_s`=1: load `letter` (case-folded per `UPCASE`), pulse `letter_valid`, go to IDLE.
    - `rxd_s`=0: pulse `frame_err`, leave `letter` unchanged, go to BREAK.
  - BREAK: wait for `rxd_s`=1, then go to IDLE. This ensures a held-low line produces exactly one `frame_err`.
- `letter_valid` and `frame_err` are never high in the same cycle.
- Case fold is an exact range compare. 0x40, 0x5B, 0x60 and 0x7B pass unchanged.
- Reset values:
  - FSM in IDLE, counter and bit index 0, shift register 0x00, synchroniser flops 1.
  - `letter`=0x00, `letter_valid`=0, `frame_err`=0.
- Reset asserted mid-frame abandons the frame. After release, the FSM waits in IDLE for a new falling edge; a partial frame never produces an output.

## Timing
- Cycle 0 is the first cycle in which IDLE sees `rxd_s`=0. `rxd_s` lags the pin by 2 cycles.
- Sample points:
  - start bit at cycle H;
  - data bit i (0–7) at cycle H + (i+1)·`CLKS_PER_BIT`;
  - stop bit at cycle H + 9·`CLKS_PER_BIT`.
- `letter` / `letter_valid` / `frame_err` are registered at the stop-sample edge and visible in cycle H + 9·`CLKS_PER_BIT` + 1.
- IDLE is re-entered in the cycle after the stop sample, so a start bit immediately following the stop bit is accepted back-to-back with no lost frame.
- A low pulse shorter than H cycles on `rxd_s` is rejected as a false start, with no output.
- There is no backpressure. The downstream stage must consume `letter` within 10·`CLKS_PER_BIT` cycles; `letter` is held stable until then.

## Structure
- Shared package `name_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, BREAK).
  - ASCII constants `ASCII_LC_A`=0x61, `ASCII_LC_Z`=0x7A, `ASCII_CASE_OFS`=0x20.
  - 8-bit letter typedef, shared with the detector.
- One sub-module, `rx_sync`: the 2-flop synchroniser with parameterised reset value (1 here), async active-low reset.
- Counter width is $clog2(`CLKS_PER_BIT`).

## Test plan
- `CLKS_PER_BIT`=4, `UPCASE`=1, send 0x52 (`R`) → `letter`=0x52 with one `letter_valid` pulse, exactly at cycle H+9·4+1 = 39 after cycle 0; `frame_err` stays 0.
- Send 0x72 (`r`) → `letter`=0x52 with `UPCASE`=1 and 0x72 with `UPCASE`=0. Send 0x7B and 0x40 → passed unchanged in both builds.
- Back-to-back frames with no idle gap spelling `RITUSHREE` → nine `letter_valid` pulses, `letter` = 0x52,0x49,0x54,0x55,0x53,0x48,0x52,0x45,0x45 in order.
- 1-cycle low glitch on `rxd` while idle → no `letter_valid`, no `frame_err`, `letter` unchanged.
- Frame for 0x41 with stop bit driven low, line held low for 3 bit times, then a valid 0x42 frame → one `frame_err` pulse, `letter` stays at its prior value, then `letter`=0x42 with one `letter_valid` pulse.
- `rst`=0 for 2 cycles during data bit 4 of a frame, then a clean 0x45 frame → no output for the aborted frame; all outputs at reset values during reset; `letter`=0x45 afterwards.

Source files
------------

// File: rtl/name_pkg.sv
// Shared types and constants for the name sequence detector and its serial front end.
package name_pkg;

  localparam int unsigned LETTER_W = 8;

  typedef logic [LETTER_W-1:0] letter_t;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  localparam letter_t ASCII_LC_A     = 8'h61;
  localparam letter_t ASCII_LC_Z     = 8'h7A;
  localparam letter_t ASCII_CASE_OFS = 8'h20;

  // Fold a-z onto A-Z when enabled; every other byte passes untouched.
  function automatic letter_t case_fold(input letter_t b, input logic upcase);
    if (upcase && (b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) begin
      return letter_t'(b - ASCII_CASE_OFS);
    end
    return b;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous input.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output, two cycles behind d
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability stage followed by the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/letter_rx.sv
// 8N1 serial receiver that turns a bit stream into ASCII letters for the
// name sequence detector, with optional lower-to-upper case folding.
//   clk          : single clock, rising edge
//   rst          : asynchronous active-low reset
//   rxd          : serial line, idle high, LSB first, asynchronous to clk
//   letter       : last correctly framed character, held until the next one
//   letter_valid : one-cycle pulse when letter takes a new value
//   frame_err    : one-cycle pulse when a stop bit is sampled low
module letter_rx
  import name_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic        UPCASE       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] letter,
  output logic       letter_valid,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 3;

  // Counter values of the last cycle before each sample edge.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

  rx_state_e        state;
  rx_state_e        state_d;
  logic             rxd_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  letter_t          shreg;
  logic             sample_c;
  logic             valid_c;
  logic             ferr_c;

  rx_sync #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(rst),
    .d    (rxd),
    .q    (rxd_s)
  );

  // Sample strobe: mid start bit, then one full bit period per data/stop bit.
  always_comb begin
    sample_c = 1'b0;
    case (state)
      START:      sample_c = (cnt == HALF_LAST);
      DATA, STOP: sample_c = (cnt == BIT_LAST);
      default:    sample_c = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (!rxd_s) state_d = START;
      START: if (sample_c) state_d = rxd_s ? IDLE : DATA;
      DATA:  if (sample_c && (idx == IDX_LAST)) state_d = STOP;
      STOP:  if (sample_c) state_d = rxd_s ? IDLE : BREAK;
      BREAK: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; a stop-bit sample yields exactly one of valid or error.
  always_comb begin
    valid_c = 1'b0;
    ferr_c  = 1'b0;
    if ((state == STOP) && sample_c) begin
      valid_c = rxd_s;
      ferr_c  = !rxd_s;
    end
  end

  // Bit timing counter, bit index and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      // Counter parks at zero while waiting so START begins counting from 0.
      if (sample_c || (state == IDLE) || (state == BREAK)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == IDLE) begin
        idx <= '0;
      end else if ((state == DATA) && sample_c) begin
        shreg[idx] <= rxd_s;
        idx        <= idx + IDX_W'(1);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      letter       <= '0;
      letter_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      letter_valid <= valid_c;
      frame_err    <= ferr_c;
      if (valid_c) begin
        letter <= case_fold(shreg, UPCASE);
      end
    end
  end

endmodule

// File: tb/tb_letter_rx.sv
// Self-checking bench for letter_rx: one case-folding and one pass-through
// instance share the serial line; a queue-based model predicts the letters.
module tb_letter_rx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] letter_u, letter_l;
  logic       lv_u, lv_l, fe_u, fe_l;

  letter_rx #(.CLKS_PER_BIT(CPB), .UPCASE(1'b1)) dut_u (
    .clk(clk), .rst(rst), .rxd(rxd),
    .letter(letter_u), .letter_valid(lv_u), .frame_err(fe_u)
  );

  letter_rx #(.CLKS_PER_BIT(CPB), .UPCASE(1'b0)) dut_l (
    .clk(clk), .rst(rst), .rxd(rxd),
    .letter(letter_l), .letter_valid(lv_l), .frame_err(fe_l)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observed events, sampled mid-cycle.
  logic [7:0]  got_u[$], got_l[$];
  logic [7:0]  exp_u[$], exp_l[$];
  int          fe_cnt_u = 0, fe_cnt_l = 0, clash = 0;
  int unsigned last_valid_cyc = 0;
  logic [7:0]  last_u = 8'h00, last_l = 8'h00;

  always @(negedge clk) begin
    if (lv_u) begin
      got_u.push_back(letter_u);
      last_valid_cyc = cyc;
    end
    if (lv_l) got_l.push_back(letter_l);
    if (fe_u) fe_cnt_u++;
    if (fe_l) fe_cnt_l++;
    if ((lv_u && fe_u) || (lv_l && fe_l)) clash++;
  end

  function automatic logic [7:0] model_fold(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  task automatic expect_byte(input logic [7:0] b);
    exp_u.push_back(model_fold(b));
    exp_l.push_back(b);
    last_u = model_fold(b);
    last_l = b;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    check({tag, "_count_u"}, got_u.size(), exp_u.size());
    check({tag, "_count_l"}, got_l.size(), exp_l.size());
    for (int i = 0; i < exp_u.size(); i++)
      if (i < got_u.size()) check($sformatf("%s_u[%0d]", tag, i), got_u[i], exp_u[i]);
    for (int i = 0; i < exp_l.size(); i++)
      if (i < got_l.size()) check($sformatf("%s_l[%0d]", tag, i), got_l[i], exp_l[i]);
    got_u.delete(); got_l.delete(); exp_u.delete(); exp_l.delete();
  endtask

  task automatic send_bit(input logic v, input int n);
    rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bit(b[i], CPB);
    send_bit(stop, CPB);
  endtask

  initial begin
    int unsigned t0;
    logic [7:0]  word[9];
    logic [7:0]  rb;

    // Reset state
    rst = 1'b0;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_letter_u", letter_u, 8'h00);
    check("rst_letter_l", letter_l, 8'h00);
    check("rst_valid", {lv_u, lv_l}, 2'b00);
    check("rst_ferr", {fe_u, fe_l}, 2'b00);
    rst = 1'b1;
    send_bit(1'b1, 8);

    // Single frame 'R' with exact latency from the pin falling edge
    last_valid_cyc = 0;
    t0 = cyc;
    send_frame(8'h52, 1'b1);
    expect_byte(8'h52);
    send_bit(1'b1, 8);
    check("latency_R", last_valid_cyc - t0, 41);
    check("letter_R_held", letter_u, 8'h52);
    compare("frame_R");
    check("ferr_after_R", fe_cnt_u + fe_cnt_l, 0);

    // Case-fold boundaries
    send_frame(8'h72, 1'b1); expect_byte(8'h72); send_bit(1'b1, 5);
    send_frame(8'h7B, 1'b1); expect_byte(8'h7B); send_bit(1'b1, 3);
    send_frame(8'h40, 1'b1); expect_byte(8'h40); send_bit(1'b1, 2);
    send_frame(8'h60, 1'b1); expect_byte(8'h60); send_bit(1'b1, 2);
    send_frame(8'h7A, 1'b1); expect_byte(8'h7A); send_bit(1'b1, 2);
    send_frame(8'h61, 1'b1); expect_byte(8'h61); send_bit(1'b1, 8);
    compare("fold");

    // Back-to-back RITUSHREE, no idle gap
    word = '{8'h52, 8'h49, 8'h54, 8'h55, 8'h53, 8'h48, 8'h52, 8'h45, 8'h45};
    for (int i = 0; i < 9; i++) begin
      send_frame(word[i], 1'b1);
      expect_byte(word[i]);
    end
    send_bit(1'b1, 8);
    compare("b2b");

    // One-cycle glitch while idle
    send_bit(1'b0, 1);
    send_bit(1'b1, 60);
    compare("glitch");
    check("glitch_ferr", fe_cnt_u + fe_cnt_l, 0);
    check("glitch_letter_u", letter_u, last_u);
    check("glitch_letter_l", letter_l, last_l);

    // Framing error, line held low, then recovery
    send_frame(8'h41, 1'b0);
    send_bit(1'b0, 3 * CPB);
    check("ferr_count_u", fe_cnt_u, 1);
    check("ferr_count_l", fe_cnt_l, 1);
    check("ferr_letter_u", letter_u, last_u);
    check("ferr_letter_l", letter_l, last_l);
    send_bit(1'b1, 8);
    send_frame(8'h42, 1'b1);
    expect_byte(8'h42);
    send_bit(1'b1, 8);
    compare("after_ferr");
    check("ferr_total_u", fe_cnt_u, 1);

    // Reset during data bit 4 of a 0x45 frame
    send_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bit(((8'h45 >> i) & 8'h01) != 8'h00, CPB);
    send_bit(1'b0, 2);
    rst = 1'b0;
    rxd = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_letter_u", letter_u, 8'h00);
    check("midrst_letter_l", letter_l, 8'h00);
    check("midrst_valid_ferr", {lv_u, lv_l, fe_u, fe_l}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    last_u = 8'h00;
    last_l = 8'h00;
    send_bit(1'b1, 60);
    compare("aborted");
    check("aborted_letter_u", letter_u, last_u);
    send_frame(8'h45, 1'b1);
    expect_byte(8'h45);
    send_bit(1'b1, 8);
    compare("after_rst");

    // Random bytes with random short gaps
    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1);
      expect_byte(rb);
      send_bit(1'b1, int'($urandom_range(0, 3)));
    end
    send_bit(1'b1, 8);
    compare("random");
    check("random_letter_u", letter_u, last_u);
    check("random_letter_l", letter_l, last_l);

    check("ferr_final_l", fe_cnt_l, 1);
    check("no_valid_ferr_overlap", clash, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
